mem_arbiter: RTL and testbench

Arbiter and sequencer for the single-port unified memory shared by the instruction-fetch (IF) and data-memory (MEM) stages of the pipelined core. It accepts fetch requests from IF and `ld`/`sd` requests from MEM, driven by the decoder's `memRead`/`memWrite` controls. It issues one transaction at a time to a variable-latency memory with a req/ack handshake. It generates the stall signals that freeze the pipeline while an access is outstanding.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_watchdog.sv | 33 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: sequencer states and
// default bus widths, also reused by the pipeline top.
package mem_arbiter_pkg;

   localparam int ADDR_W_DEF  = 64;
   localparam int DATA_W_DEF  = 64;
   localparam int TIMEOUT_DEF = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      IF_WAIT = 3'd1,
      DM_WAIT = 3'd2,
      IF_DONE = 3'd3,
      DM_DONE = 3'd4
   } arbState_t;

   function automatic logic isWait(input arbState_t s);
      return (s == IF_WAIT) || (s == DM_WAIT);
   endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Watchdog for unacknowledged memory requests; raises a sticky flag once a
// single transaction has waited TIMEOUT cycles.
module arb_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] count_r;

   // Wait-cycle counter saturating at the limit; flag sets on reaching it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r     <= {CNT_W{1'b0}};
         timeout_err <= 1'b0;
      end else if (clear) begin
         count_r <= {CNT_W{1'b0}};
      end else if (run && (count_r != LIMIT)) begin
         count_r <= count_r + CNT_W'(1);
         if ((count_r + CNT_W'(1)) == LIMIT) begin
            timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the single-port memory shared by IF and MEM stages:
// one transaction at a time, data before fetch, pipeline stalls while busy.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              flush,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_read,
   input  logic              dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall_front,
   output logic              stall_all,
   output logic              timeout_err
);

   arbState_t state_r;
   logic      kill_r;
   logic      dmReq_s;
   logic      wdClear_s;
   logic      wdRun_s;

   assign dmReq_s     = dm_read | dm_write;
   assign stall_all   = dmReq_s & ~dm_valid;
   assign stall_front = stall_all | (if_req & ~if_valid);
   assign wdClear_s   = (state_r == IDLE) & (dmReq_s | if_req);
   assign wdRun_s     = isWait(state_r) & ~mem_ack;

   // Sequencer: issue, wait for ack, one-cycle completion pulse, back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= {ADDR_W{1'b0}};
         mem_wdata <= {DATA_W{1'b0}};
         if_rdata  <= {DATA_W{1'b0}};
         dm_rdata  <= {DATA_W{1'b0}};
         if_valid  <= 1'b0;
         dm_valid  <= 1'b0;
         kill_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (dmReq_s) begin
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  mem_we    <= dm_write;
                  mem_req   <= 1'b1;
                  state_r   <= DM_WAIT;
               end else if (if_req) begin
                  mem_addr <= if_addr;
                  mem_we   <= 1'b0;
                  mem_req  <= 1'b1;
                  state_r  <= IF_WAIT;
               end else begin
                  state_r <= IDLE;
               end
            end
            IF_WAIT: begin
               // A flushed fetch still finishes on the bus; only its result is dropped.
               if (flush) begin
                  kill_r <= 1'b1;
               end
               if (mem_ack) begin
                  if_rdata <= mem_rdata;
                  if_valid <= ~(kill_r | flush);
                  mem_req  <= 1'b0;
                  state_r  <= IF_DONE;
               end
            end
            DM_WAIT: begin
               if (mem_ack) begin
                  dm_rdata <= mem_rdata;
                  dm_valid <= 1'b1;
                  mem_req  <= 1'b0;
                  state_r  <= DM_DONE;
               end
            end
            IF_DONE: begin
               if_valid <= 1'b0;
               kill_r   <= 1'b0;
               state_r  <= IDLE;
            end
            DM_DONE: begin
               dm_valid <= 1'b0;
               state_r  <= IDLE;
            end
            default: begin
               mem_req  <= 1'b0;
               if_valid <= 1'b0;
               dm_valid <= 1'b0;
               kill_r   <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

   arb_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) uWatchdog (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (wdClear_s),
      .run        (wdRun_s),
      .timeout_err(timeout_err)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a variable-latency memory responder
// plus bus/result scoreboards, driven by one task per scenario.
module tb_mem_arbiter;

   typedef struct packed {
      logic        isWrite;
      logic [63:0] addr;
      logic [63:0] wdata;
   } busExp_t;

   typedef struct packed {
      logic        isData;
      logic [63:0] data;
   } resExp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, flush, dm_read, dm_write, mem_ack;
   logic [63:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [63:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_valid, dm_valid, mem_req, mem_we;
   logic        stall_front, stall_all, timeout_err;

   int          checks = 0;
   int          passes = 0;
   int          memLatency = 1;
   int          waitCnt = 0;
   logic [63:0] rdataXor = 64'h0;
   logic        reqSeen = 1'b0;
   logic [63:0] curAddr, curWdata;
   logic        curWe;
   busExp_t     busQ[$];
   resExp_t     resQ[$];

   localparam logic [63:0] XOR_PAT = 64'hF0F0_1234_0000_0000;

   mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .flush(flush),
      .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall_front(stall_front), .stall_all(stall_all), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem_addr ^ rdataXor;

   // Memory responder and scoreboard monitor, evaluated away from the active edge.
   initial begin
      busExp_t be;
      resExp_t re;
      mem_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            waitCnt++;
            checks++;
            if (!reqSeen) begin
               reqSeen  = 1'b1;
               curAddr  = mem_addr;
               curWe    = mem_we;
               curWdata = mem_wdata;
               if (busQ.size() == 0) begin
                  $display("FAIL bus_unexpected: got addr=%h we=%b, none expected", mem_addr, mem_we);
               end else begin
                  be = busQ.pop_front();
                  if (mem_addr !== be.addr || mem_we !== be.isWrite ||
                      (be.isWrite && mem_wdata !== be.wdata))
                     $display("FAIL bus_issue: got addr=%h we=%b wdata=%h, need addr=%h we=%b wdata=%h",
                              mem_addr, mem_we, mem_wdata, be.addr, be.isWrite, be.wdata);
                  else
                     passes++;
               end
            end else begin
               if (mem_addr !== curAddr || mem_we !== curWe || mem_wdata !== curWdata)
                  $display("FAIL bus_stable: got addr=%h we=%b wdata=%h, need addr=%h we=%b wdata=%h",
                           mem_addr, mem_we, mem_wdata, curAddr, curWe, curWdata);
               else
                  passes++;
            end
            mem_ack = (memLatency != 0) && (waitCnt == memLatency);
         end else begin
            waitCnt = 0;
            reqSeen = 1'b0;
            mem_ack = 1'b0;
         end
         if (if_valid || dm_valid) begin
            checks++;
            if (if_valid && dm_valid) begin
               $display("FAIL both_valid: if_valid=1 dm_valid=1, need at most one");
            end else if (resQ.size() == 0) begin
               $display("FAIL result_unexpected: got if_valid=%b dm_valid=%b, none expected", if_valid, dm_valid);
            end else begin
               re = resQ.pop_front();
               if (re.isData !== dm_valid || (dm_valid ? dm_rdata : if_rdata) !== re.data)
                  $display("FAIL result: got data-side=%b data=%h, need data-side=%b data=%h",
                           dm_valid, (dm_valid ? dm_rdata : if_rdata), re.isData, re.data);
               else
                  passes++;
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; if_req = 1'b0; flush = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
      if_addr = 64'h0; dm_addr = 64'h0; dm_wdata = 64'h0;
      repeat (2) @(negedge clk);
      checks++;
      if ({mem_req, mem_we, if_valid, dm_valid, timeout_err, stall_front, stall_all} !== 7'b0 ||
          mem_addr !== 64'h0 || mem_wdata !== 64'h0 || if_rdata !== 64'h0 || dm_rdata !== 64'h0)
         $display("FAIL reset_state: got req=%b we=%b iv=%b dv=%b to=%b sf=%b sa=%b addr=%h, need all zero",
                  mem_req, mem_we, if_valid, dm_valid, timeout_err, stall_front, stall_all, mem_addr);
      else
         passes++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fetch();
      int reqCycles = 0;
      int validAt = -1;
      memLatency = 2;
      rdataXor = 64'h100 ^ 64'h00A0_0093;
      if_req = 1'b1; if_addr = 64'h100;
      busQ.push_back('{1'b0, 64'h100, 64'h0});
      resQ.push_back('{1'b0, 64'h00A0_0093});
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (mem_req) reqCycles++;
         checks++;
         if (stall_front !== (k != 3))
            $display("FAIL fetch_stall_front: cycle %0d got %b, need %b", k, stall_front, (k != 3));
         else
            passes++;
         if (if_valid) begin
            validAt = k;
            break;
         end
      end
      if_req = 1'b0;
      checks++;
      if (reqCycles !== 2) $display("FAIL fetch_req_cycles: got %0d, need 2", reqCycles);
      else passes++;
      checks++;
      if (validAt + 1 !== 4) $display("FAIL fetch_access_cycles: got %0d, need 4", validAt + 1);
      else passes++;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || stall_front !== 1'b0)
         $display("FAIL fetch_idle_after: got req=%b stall_front=%b, need 0 0", mem_req, stall_front);
      else
         passes++;
   endtask

   task automatic test_priority();
      int dmAt = -1;
      int ifAt = -1;
      int fetchReqAt = -1;
      memLatency = 1;
      rdataXor = XOR_PAT;
      if_req = 1'b1; if_addr = 64'h104; dm_read = 1'b1; dm_addr = 64'h2000;
      busQ.push_back('{1'b0, 64'h2000, 64'h0});
      busQ.push_back('{1'b0, 64'h104, 64'h0});
      resQ.push_back('{1'b1, 64'h2000 ^ XOR_PAT});
      resQ.push_back('{1'b0, 64'h104 ^ XOR_PAT});
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (mem_req && mem_addr == 64'h104 && fetchReqAt < 0) fetchReqAt = k;
         if (dmAt < 0) begin
            checks++;
            if (stall_all !== (k < 2))
               $display("FAIL prio_stall_all: cycle %0d got %b, need %b", k, stall_all, (k < 2));
            else
               passes++;
            if (dm_valid) begin
               dmAt = k;
               dm_read = 1'b0;
            end
         end
         if (if_valid) begin
            ifAt = k;
            break;
         end
      end
      if_req = 1'b0;
      checks++;
      if (dmAt !== 2 || fetchReqAt !== 4 || ifAt !== 5)
         $display("FAIL prio_sequence: got dm_valid@%0d fetch_req@%0d if_valid@%0d, need 2 4 5",
                  dmAt, fetchReqAt, ifAt);
      else
         passes++;
      @(negedge clk);
   endtask

   task automatic test_store();
      int reqCycles = 0;
      int validCnt = 0;
      memLatency = 3;
      dm_write = 1'b1; dm_addr = 64'h3008; dm_wdata = 64'hDEAD_BEEF;
      busQ.push_back('{1'b1, 64'h3008, 64'hDEAD_BEEF});
      resQ.push_back('{1'b1, 64'h3008 ^ XOR_PAT});
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (mem_req) reqCycles++;
         if (dm_valid) begin
            validCnt++;
            dm_write = 1'b0;
         end
      end
      checks++;
      if (reqCycles !== 3 || validCnt !== 1)
         $display("FAIL store_shape: got req_cycles=%0d dm_valid_pulses=%0d, need 3 1", reqCycles, validCnt);
      else
         passes++;
   endtask

   task automatic test_flush();
      int rises = 0;
      int validAt = -1;
      logic prevReq = 1'b0;
      memLatency = 3;
      if_req = 1'b1; if_addr = 64'h200;
      busQ.push_back('{1'b0, 64'h200, 64'h0});
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 2) begin
            flush = 1'b1;
            if_addr = 64'h300;
            busQ.push_back('{1'b0, 64'h300, 64'h0});
            resQ.push_back('{1'b0, 64'h300 ^ XOR_PAT});
         end else begin
            flush = 1'b0;
         end
         if (mem_req && !prevReq) rises++;
         prevReq = mem_req;
         if (if_valid) begin
            validAt = k;
            break;
         end
      end
      if_req = 1'b0;
      checks++;
      if (rises !== 2 || validAt !== 9)
         $display("FAIL flush_kill: got bus_txns=%0d if_valid@%0d, need 2 9", rises, validAt);
      else
         passes++;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int validAt = -1;
      memLatency = 22;
      dm_read = 1'b1; dm_addr = 64'h4000;
      busQ.push_back('{1'b0, 64'h4000, 64'h0});
      resQ.push_back('{1'b1, 64'h4000 ^ XOR_PAT});
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 16) begin
            checks++;
            if (timeout_err !== 1'b0) $display("FAIL timeout_early: wait cycle 16 got %b, need 0", timeout_err);
            else passes++;
         end
         if (k == 17 || k == 22) begin
            checks++;
            if (timeout_err !== 1'b1) $display("FAIL timeout_set: wait cycle %0d got %b, need 1", k, timeout_err);
            else passes++;
         end
         if (dm_valid) begin
            validAt = k;
            dm_read = 1'b0;
            break;
         end
      end
      dm_read = 1'b0;
      checks++;
      if (validAt !== 23) $display("FAIL timeout_late_ack: dm_valid@%0d, need 23", validAt);
      else passes++;
      repeat (2) @(negedge clk);
      checks++;
      if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b, need 1", timeout_err);
      else passes++;
   endtask

   task automatic test_reset_mid();
      int reqAt = -1;
      int validAt = -1;
      memLatency = 0;
      dm_read = 1'b1; dm_addr = 64'h5000;
      busQ.push_back('{1'b0, 64'h5000, 64'h0});
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || dm_valid !== 1'b0 || timeout_err !== 1'b0)
         $display("FAIL reset_async: got req=%b dv=%b to=%b, need 0 0 0", mem_req, dm_valid, timeout_err);
      else
         passes++;
      dm_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      memLatency = 1;
      if_req = 1'b1; if_addr = 64'h600;
      busQ.push_back('{1'b0, 64'h600, 64'h0});
      resQ.push_back('{1'b0, 64'h600 ^ XOR_PAT});
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (mem_req && reqAt < 0) reqAt = k;
         if (if_valid) begin
            validAt = k;
            break;
         end
      end
      if_req = 1'b0;
      checks++;
      if (reqAt !== 1 || validAt !== 2)
         $display("FAIL reset_then_fetch: got req@%0d if_valid@%0d, need 1 2", reqAt, validAt);
      else
         passes++;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_store();
      test_flush();
      test_timeout();
      test_reset_mid();
      repeat (2) @(negedge clk);
      checks++;
      if (busQ.size() != 0 || resQ.size() != 0)
         $display("FAIL scoreboard_drain: got %0d bus and %0d results left, need 0 0", busQ.size(), resQ.size());
      else
         passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
